// File: rtl/level_det_pkg.sv
// Shared types and defaults for the level hysteresis detector.
package level_det_pkg;

  localparam int DEF_DW   = 24;
  localparam int DEF_HOLD = 4;
  localparam int DEF_CW   = 16;
  localparam int HCNT_W   = 8;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_RISING  = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FALLING = 2'd3
  } state_e;

  // Debounced level implied by an FSM state: high while in or leaving a high episode.
  function automatic logic level_of(input state_e st);
    return (st == ST_HIGH) || (st == ST_FALLING);
  endfunction

endpackage

// File: rtl/level_hyst_detector_peak_tracker.sv
// Running maximum of a high episode. `seed` starts a new episode with the
// current sample, `upd` folds the sample into the running max, and `latch`
// publishes the final max (including the current sample) on peak_out.
module peak_tracker #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          seed,
  input  logic          upd,
  input  logic          latch,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] peak_out
);

  logic [DW-1:0] peak_r;
  logic [DW-1:0] peak_out_r;
  logic [DW-1:0] peak_max_s;

  assign peak_max_s = (sample > peak_r) ? sample : peak_r;
  assign peak_out   = peak_out_r;

  // Running max register: seeded on rise confirmation, updated during the episode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_r <= {DW{1'b0}};
    end else if (seed) begin
      peak_r <= sample;
    end else if (upd) begin
      peak_r <= peak_max_s;
    end else begin
      peak_r <= peak_r;
    end
  end

  // Published peak: captures the final max on fall confirmation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_out_r <= {DW{1'b0}};
    end else if (latch) begin
      peak_out_r <= peak_max_s;
    end else begin
      peak_out_r <= peak_out_r;
    end
  end

endmodule

// File: rtl/level_hyst_detector.sv
// Hysteresis threshold detector with hold-count debounce, rise/fall pulses,
// episode peak reporting and a saturating rise counter.
module level_hyst_detector
  import level_det_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int HOLD = DEF_HOLD,
  parameter int CW   = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] data_in,
  input  logic          data_vld,
  input  logic [DW-1:0] th_hi,
  input  logic [DW-1:0] th_lo,
  output logic          level,
  output logic          rise_pulse,
  output logic          fall_pulse,
  output logic [DW-1:0] peak_out,
  output logic          peak_vld,
  output logic [CW-1:0] event_cnt,
  output logic          cfg_err
);

  localparam logic [HCNT_W-1:0] HOLD_C = HCNT_W'(HOLD);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [HCNT_W-1:0]   hcnt_r;
  logic [HCNT_W-1:0]   hcnt_nxt_s;
  logic [HCNT_W-1:0]   hcnt_inc_s;

  logic                cfg_bad_s;
  logic                accept_s;
  logic                q_hi_s;
  logic                q_lo_s;

  logic                rise_s;
  logic                fall_s;
  logic                upd_s;

  logic                level_r;
  logic                rise_pulse_r;
  logic                fall_pulse_r;
  logic                peak_vld_r;
  logic                cfg_err_r;
  logic [CW-1:0]       event_cnt_r;

  // A crossed threshold pair freezes everything; only valid, well-configured samples advance.
  assign cfg_bad_s  = (th_lo > th_hi);
  assign accept_s   = data_vld & ~cfg_bad_s;
  assign q_hi_s     = (data_in > th_hi);
  assign q_lo_s     = (data_in < th_lo);
  assign hcnt_inc_s = hcnt_r + {{(HCNT_W-1){1'b0}}, 1'b1};

  // State and hold-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOW;
      hcnt_r  <= {HCNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
    end
  end

  // Next-state and hold-count logic; a single qualifying sample confirms when HOLD is 1.
  always_comb begin
    state_nxt_s = state_r;
    hcnt_nxt_s  = hcnt_r;
    if (accept_s) begin
      case (state_r)
        ST_LOW: begin
          if (q_hi_s) begin
            if (HOLD_C <= 8'd1) begin
              state_nxt_s = ST_HIGH;
              hcnt_nxt_s  = {HCNT_W{1'b0}};
            end else begin
              state_nxt_s = ST_RISING;
              hcnt_nxt_s  = 8'd1;
            end
          end else begin
            hcnt_nxt_s = {HCNT_W{1'b0}};
          end
        end
        ST_RISING: begin
          if (q_hi_s) begin
            if (hcnt_inc_s >= HOLD_C) begin
              state_nxt_s = ST_HIGH;
              hcnt_nxt_s  = {HCNT_W{1'b0}};
            end else begin
              hcnt_nxt_s = hcnt_inc_s;
            end
          end else begin
            state_nxt_s = ST_LOW;
            hcnt_nxt_s  = {HCNT_W{1'b0}};
          end
        end
        ST_HIGH: begin
          if (q_lo_s) begin
            if (HOLD_C <= 8'd1) begin
              state_nxt_s = ST_LOW;
              hcnt_nxt_s  = {HCNT_W{1'b0}};
            end else begin
              state_nxt_s = ST_FALLING;
              hcnt_nxt_s  = 8'd1;
            end
          end else begin
            hcnt_nxt_s = {HCNT_W{1'b0}};
          end
        end
        ST_FALLING: begin
          if (q_lo_s) begin
            if (hcnt_inc_s >= HOLD_C) begin
              state_nxt_s = ST_LOW;
              hcnt_nxt_s  = {HCNT_W{1'b0}};
            end else begin
              hcnt_nxt_s = hcnt_inc_s;
            end
          end else begin
            state_nxt_s = ST_HIGH;
            hcnt_nxt_s  = {HCNT_W{1'b0}};
          end
        end
        default: begin
          state_nxt_s = ST_LOW;
          hcnt_nxt_s  = {HCNT_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      hcnt_nxt_s  = hcnt_r;
    end
  end

  // Transition strobes: rise/fall are the confirmations, upd tracks the peak during an episode.
  always_comb begin
    rise_s = 1'b0;
    fall_s = 1'b0;
    upd_s  = 1'b0;
    if (accept_s) begin
      rise_s = !level_of(state_r) && (state_nxt_s == ST_HIGH);
      fall_s = level_of(state_r) && (state_nxt_s == ST_LOW);
      upd_s  = level_of(state_r);
    end else begin
      rise_s = 1'b0;
      fall_s = 1'b0;
      upd_s  = 1'b0;
    end
  end

  // Registered level, pulses and configuration flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r      <= 1'b0;
      rise_pulse_r <= 1'b0;
      fall_pulse_r <= 1'b0;
      peak_vld_r   <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      level_r      <= level_of(state_nxt_s);
      rise_pulse_r <= rise_s;
      fall_pulse_r <= fall_s;
      peak_vld_r   <= fall_s;
      cfg_err_r    <= cfg_bad_s;
    end
  end

  // Saturating count of confirmed rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_cnt_r <= {CW{1'b0}};
    end else if (rise_s && (event_cnt_r != {CW{1'b1}})) begin
      event_cnt_r <= event_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      event_cnt_r <= event_cnt_r;
    end
  end

  peak_tracker #(
    .DW (DW)
  ) u_peak (
    .clk      (clk),
    .rst_n    (rst_n),
    .seed     (rise_s),
    .upd      (upd_s),
    .latch    (fall_s),
    .sample   (data_in),
    .peak_out (peak_out)
  );

  assign level      = level_r;
  assign rise_pulse = rise_pulse_r;
  assign fall_pulse = fall_pulse_r;
  assign peak_vld   = peak_vld_r;
  assign event_cnt  = event_cnt_r;
  assign cfg_err    = cfg_err_r;

endmodule

// File: tb/tb_level_hyst_detector.sv
// Directed bench for level_hyst_detector: a CW=16 instance and a CW=4
// instance share the same stimulus; the second exercises counter saturation.
module tb_level_hyst_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] data_in;
  logic        data_vld;
  logic [23:0] th_hi;
  logic [23:0] th_lo;

  logic        level_a, rise_a, fall_a, pvld_a, cerr_a;
  logic [23:0] peak_a;
  logic [15:0] ev_a;

  logic        level_b, rise_b, fall_b, pvld_b, cerr_b;
  logic [23:0] peak_b;
  logic [3:0]  ev_b;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ev = 0;

  level_hyst_detector #(.DW(24), .HOLD(4), .CW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld),
    .th_hi(th_hi), .th_lo(th_lo), .level(level_a), .rise_pulse(rise_a),
    .fall_pulse(fall_a), .peak_out(peak_a), .peak_vld(pvld_a),
    .event_cnt(ev_a), .cfg_err(cerr_a)
  );

  level_hyst_detector #(.DW(24), .HOLD(4), .CW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld),
    .th_hi(th_hi), .th_lo(th_lo), .level(level_b), .rise_pulse(rise_b),
    .fall_pulse(fall_b), .peak_out(peak_b), .peak_vld(pvld_b),
    .event_cnt(ev_b), .cfg_err(cerr_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then land 1 time unit after the edge that consumes it.
  task automatic step(input logic [23:0] d, input logic v);
    data_in  = d;
    data_vld = v;
    @(posedge clk);
    #1;
  endtask

  // Drive four low samples and check the fall confirms on the last with the given peak.
  task automatic fall_seq(input string tag, input logic [23:0] d, input logic [23:0] pk);
    for (int i = 0; i < 4; i++) begin
      step(d, 1'b1);
      check_eq({tag, "_fall"}, fall_a, (i == 3));
      check_eq({tag, "_pvld"}, pvld_a, (i == 3));
      check_eq({tag, "_level"}, level_a, (i != 3));
    end
    check_eq({tag, "_peak"}, peak_a, pk);
  endtask

  initial begin
    int g[8];
    rst_n    = 1'b0;
    data_in  = 24'd0;
    data_vld = 1'b0;
    th_hi    = 24'd80;
    th_lo    = 24'd20;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_level", level_a, 0);
    check_eq("rst_rise", rise_a, 0);
    check_eq("rst_fall", fall_a, 0);
    check_eq("rst_pvld", pvld_a, 0);
    check_eq("rst_peak", peak_a, 0);
    check_eq("rst_ev", ev_a, 0);
    check_eq("rst_cfg", cerr_a, 0);
    rst_n = 1'b1;

    // Sawtooth 0..100, two periods plus a short tail.
    for (int p = 0; p < 2; p++) begin
      for (int s = 0; s <= 100; s++) begin
        step(24'(s), 1'b1);
        check_eq("saw_rise", rise_a, (s == 84));
        check_eq("saw_fall", fall_a, (p == 1 && s == 3));
        check_eq("saw_pvld", pvld_a, (p == 1 && s == 3));
        check_eq("saw_level", level_a, (s >= 84) || (p == 1 && s < 3));
        if (p == 1 && s == 3) check_eq("saw_peak", peak_a, 100);
      end
      exp_ev++;
      check_eq("saw_ev", ev_a, exp_ev);
    end
    for (int s = 0; s <= 5; s++) begin
      step(24'(s), 1'b1);
      check_eq("tail_fall", fall_a, (s == 3));
      check_eq("tail_level", level_a, (s < 3));
    end
    check_eq("tail_peak", peak_a, 100);

    // Glitch rejection: the 50 restarts the hold count.
    g = '{90, 90, 90, 50, 90, 90, 90, 90};
    for (int i = 0; i < 8; i++) begin
      step(24'(g[i]), 1'b1);
      check_eq("glitch_rise", rise_a, (i == 7));
      check_eq("glitch_level", level_a, (i == 7));
    end
    exp_ev++;
    check_eq("glitch_ev", ev_a, exp_ev);
    fall_seq("glitch", 24'd0, 24'd90);

    // Invalid cycles neither break nor extend a run.
    for (int i = 0; i < 4; i++) begin
      step(24'd90, 1'b1);
      check_eq("gap_rise", rise_a, (i == 3));
      for (int j = 0; j < 3; j++) begin
        step(24'd0, 1'b0);
        check_eq("gap_idle_rise", rise_a, 0);
        check_eq("gap_idle_level", level_a, (i == 3));
      end
    end
    exp_ev++;
    check_eq("gap_ev", ev_a, exp_ev);
    fall_seq("gap", 24'd5, 24'd90);

    // Crossed thresholds freeze the detector.
    th_lo = 24'd90;
    th_hi = 24'd10;
    for (int i = 0; i < 6; i++) begin
      step(24'd200, 1'b1);
      check_eq("cfg_err_on", cerr_a, 1);
      check_eq("cfg_level", level_a, 0);
      check_eq("cfg_rise", rise_a, 0);
    end
    check_eq("cfg_ev", ev_a, exp_ev);
    th_lo = 24'd20;
    th_hi = 24'd80;
    for (int i = 0; i < 4; i++) begin
      step(24'd200, 1'b1);
      check_eq("cfg_err_off", cerr_a, 0);
      check_eq("cfg_rec_rise", rise_a, (i == 3));
    end
    exp_ev++;
    fall_seq("cfg", 24'd0, 24'd200);

    // Twenty more episodes; the 4-bit counter must stick at 15.
    for (int k = 0; k < 20; k++) begin
      repeat (4) step(24'd200, 1'b1);
      repeat (4) step(24'd0, 1'b1);
      exp_ev++;
    end
    check_eq("sat_ev_a", ev_a, exp_ev);
    check_eq("sat_ev_b", ev_b, 15);

    // Zero hysteresis: a sample equal to the threshold qualifies neither way.
    th_lo = 24'd50;
    th_hi = 24'd50;
    for (int i = 0; i < 5; i++) begin
      step(24'd50, 1'b1);
      check_eq("eq_low_level", level_a, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(24'd51, 1'b1);
      check_eq("eq_rise", rise_a, (i == 3));
    end
    for (int i = 0; i < 5; i++) begin
      step(24'd50, 1'b1);
      check_eq("eq_hold_level", level_a, 1);
      check_eq("eq_hold_fall", fall_a, 0);
    end
    fall_seq("eq", 24'd49, 24'd51);
    exp_ev++;
    check_eq("eq_ev_a", ev_a, exp_ev);
    check_eq("eq_ev_b", ev_b, 15);

    // Reset while FALLING: level drops at once, no fall report.
    th_lo = 24'd20;
    th_hi = 24'd80;
    repeat (4) step(24'd200, 1'b1);
    check_eq("mid_level_hi", level_a, 1);
    repeat (2) step(24'd0, 1'b1);
    check_eq("mid_level_falling", level_a, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_level", level_a, 0);
    check_eq("mid_rst_peak", peak_a, 0);
    check_eq("mid_rst_ev", ev_a, 0);
    check_eq("mid_rst_fall", fall_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(24'd0, 1'b1);
      check_eq("post_rst_fall", fall_a, 0);
      check_eq("post_rst_pvld", pvld_a, 0);
      check_eq("post_rst_level", level_a, 0);
    end
    check_eq("post_rst_peak", peak_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
